apu_pulse_sequencer: RTL and testbench
======================================

Name: apu_pulse_sequencer

Overview:
Step sequencer that drives the period and duty configuration streams of an apu_pulse channel.
- Holds a small pattern table of {period, duty} entries, written by the host.
- While running, it issues one entry per step as valid/ready transactions on the channel's period and duty inputs.
- Steps are paced by a programmable tempo counter and loop over entries 0..last_idx.

Parameters:
- DEPTH, 8, number of pattern entries (power of two); IDX_W = log2(DEPTH).
- TEMPO_W, 16, tempo counter width in clocks.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  reset: asynchronous assert, active-low.
- cfg_we  in  1  pattern write strobe.
- cfg_addr  in  IDX_W  pattern entry index for writes.
- cfg_period  in  11  period value to write.
- cfg_duty  in  2  duty value to write.
- last_idx  in  IDX_W  last entry of the loop.
- tempo  in  TEMPO_W  step length in clocks; 0 is treated as 1.
- run  in  1  level: sequencer enable.
- period  out  11  period stream data.
- period_vld  out  1  period stream valid.
- period_rdy  in  1  period stream ready.
- duty  out  2  duty stream data.
- duty_vld  out  1  duty stream valid.
- duty_rdy  in  1  duty stream ready.
- step_idx  out  IDX_W  entry currently issued or last issued.
- busy  out  1  high whenever the state is not IDLE.
- overrun  out  1  sticky: a step exceeded tempo waiting on handshakes.

Behaviour:
- Reset values: state IDLE; period=0, duty=0, period_vld=0, duty_vld=0; step_idx=0; busy=0; overrun=0; tempo counter=0. Pattern table contents are undefined after reset.
- Table write: on a clk edge with cfg_we=1, entry[cfg_addr] <= {cfg_period, cfg_duty}. Writes are accepted in any state.
- Data latching: issued data is latched from the table on entry to ISSUE. A write to the entry in flight does not alter period/duty until the next issue of that entry.
- FSM IDLE:
  - run=1 on a clk edge -> ISSUE next cycle.
  - The counter clears to 0; period_vld and duty_vld rise together, carrying entry[step_idx].
- FSM ISSUE:
  - Each stream is independent. A beat transfers on a clk edge with vld&rdy, and that vld drops the next cycle.
  - vld never deasserts before its transfer; data is stable while vld=1.
  - The counter increments every cycle in ISSUE and WAIT, saturating at its maximum.
  - Both beats transferred -> WAIT.
- FSM WAIT: when counter >= max(tempo,1)-1 the step ends:
  - step_idx <= (step_idx==last_idx) ? 0 : step_idx+1;
  - then run=1 -> ISSUE (counter cleared, both vld rise next cycle), else -> IDLE.
- Step end in ISSUE: if both transfers complete in the same cycle the counter reaches the limit, the step ends directly from ISSUE with the same rules, skipping WAIT.
- Overrun: if the counter reaches the limit while either vld is still pending, overrun <= 1. The step then ends on the cycle after the later transfer. overrun clears only on reset.
- run deasserted in ISSUE: pending beats still complete; the step then ends normally and the FSM goes to IDLE.
- Entering IDLE because run=0: step_idx resets to 0. Indices are already reset when the next run starts.
- Wrap: if step_idx > last_idx (last_idx lowered mid-run), the next advance goes to 0.
- Timing: with tempo=N>=1 and rdy held high, vld pulses occur every N cycles when N>=2, and every 2 cycles when N=1 (one ISSUE cycle plus one vld-low cycle).
- Reset mid-operation: all outputs return to reset values asynchronously. Beats in flight are abandoned.

Decomposition:
- Shared package apu_pkg: period_t (11-bit), duty_t (2-bit), pattern entry struct {period_t, duty_t}, state enum {IDLE, ISSUE, WAIT}. This package is shared with other APU controllers.
- One sub-module, apu_stream_out: a single-stream holding register with load/vld/rdy/done. It is instantiated twice, parameterised by data width.

Test Plan:
- Load entries 0..3 = {100,0},{200,1},{300,2},{400,3}; last_idx=3, tempo=10, rdy=1, run=1 -> period beats 100,200,300,400,100 exactly 10 cycles apart; duty 0,1,2,3,0; overrun=0.
- tempo=10, hold duty_rdy=0 for 15 cycles in step 0 -> period beat at cycle 1, duty beat at cycle 16; overrun=1; next issue at cycle 17.
- Drop run during a step with period_rdy=0 -> period_vld stays high with stable data until rdy; then IDLE, busy=0, step_idx=0.
- tempo=0 and tempo=1, rdy=1 -> one beat every 2 cycles; step_idx cycles 0..last_idx.
- Write entry[step_idx] while its beat is pending -> output data unchanged; the next loop pass issues the new value.
- Assert rst_n=0 asynchronously mid-ISSUE -> all vld=0, step_idx=0, overrun=0 before the next clk edge.

Source files
------------

// File: rtl/apu_pkg.sv
// Shared APU types: pattern entry layout and the sequencer state encoding.
package apu_pkg;

    localparam int PERIOD_W = 11;
    localparam int DUTY_W   = 2;

    typedef logic [PERIOD_W-1:0] period_t;
    typedef logic [DUTY_W-1:0]   duty_t;

    typedef struct packed {
        period_t period;
        duty_t   duty;
    } pattern_t;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT
    } state_t;

endpackage

// File: rtl/apu_pulse_sequencer_if.sv
// Host configuration plus the period/duty valid-ready streams of one pulse channel.
interface apu_pulse_sequencer_if #(
    parameter int DEPTH   = 8,
    parameter int TEMPO_W = 16
);
    import apu_pkg::*;

    localparam int IDX_W = $clog2(DEPTH);

    // Host side: pattern table writes and run control
    logic               cfg_we;
    logic [IDX_W-1:0]   cfg_addr;
    period_t            cfg_period;
    duty_t              cfg_duty;
    logic [IDX_W-1:0]   last_idx;
    logic [TEMPO_W-1:0] tempo;
    logic               run;

    // Channel side: two independent configuration streams
    period_t            period;
    logic               period_vld;
    logic               period_rdy;
    duty_t              duty;
    logic               duty_vld;
    logic               duty_rdy;

    // Status
    logic [IDX_W-1:0]   step_idx;
    logic               busy;
    logic               overrun;

    // The sequencer drives the streams and status
    modport master (
        input  cfg_we, cfg_addr, cfg_period, cfg_duty, last_idx, tempo, run,
        input  period_rdy, duty_rdy,
        output period, period_vld, duty, duty_vld,
        output step_idx, busy, overrun
    );

    // The host/channel environment around the sequencer
    modport slave (
        output cfg_we, cfg_addr, cfg_period, cfg_duty, last_idx, tempo, run,
        output period_rdy, duty_rdy,
        input  period, period_vld, duty, duty_vld,
        input  step_idx, busy, overrun
    );

endinterface

// File: rtl/apu_stream_out.sv
// Single valid/ready output stage: loads a beat, holds it stable until it transfers.
module apu_stream_out #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         i_load,
    input  logic [W-1:0] i_data,
    input  logic         i_rdy,
    output logic [W-1:0] o_data,
    output logic         o_vld,
    output logic         o_done
);

    logic         r_vld;
    logic [W-1:0] r_data;

    // Hold register: a load raises vld, a transfer (vld & rdy) drops it on the next cycle
    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_vld  <= 1'b0;
            r_data <= '0;
        end else if (i_load) begin
            r_vld  <= 1'b1;
            r_data <= i_data;
        end else if (r_vld && i_rdy) begin
            r_vld  <= 1'b0;
        end
    end

    assign o_data = r_data;
    assign o_vld  = r_vld;
    // Beat is finished by the end of this cycle: already gone, or transferring now
    assign o_done = !r_vld || i_rdy;

endmodule

// File: rtl/apu_pulse_sequencer.sv
// Step sequencer: issues one {period, duty} pattern entry per tempo step to a pulse channel.
module apu_pulse_sequencer
    import apu_pkg::*;
#(
    parameter int DEPTH   = 8,
    parameter int TEMPO_W = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    apu_pulse_sequencer_if.master bus
);

    localparam int IDX_W = $clog2(DEPTH);

    pattern_t           r_mem [DEPTH];
    state_t             r_state;
    state_t             w_state_nxt;
    logic [TEMPO_W-1:0] r_cnt;
    logic [TEMPO_W-1:0] w_cnt_nxt;
    logic [TEMPO_W-1:0] w_cnt_inc;
    logic [TEMPO_W-1:0] w_limit;
    logic [IDX_W-1:0]   r_step_idx;
    logic [IDX_W-1:0]   w_step_idx_nxt;
    logic [IDX_W-1:0]   w_adv_idx;
    logic [IDX_W-1:0]   w_load_idx;
    logic               r_overrun;
    logic               w_overrun_set;
    logic               w_load;
    logic               w_step_end;
    logic               w_period_done;
    logic               w_duty_done;
    logic               w_all_done;
    pattern_t           w_load_entry;

    // Pattern table: host writes are accepted in every state
    // NOTE: the table has no reset; its contents are don't-care until the host loads it.
    always_ff @(posedge clk) begin
        if (bus.cfg_we) begin
            r_mem[bus.cfg_addr] <= '{period: bus.cfg_period, duty: bus.cfg_duty};
        end
    end

    assign w_load_entry = r_mem[w_load_idx];
    // A tempo of zero behaves as a one-clock step
    assign w_limit      = (bus.tempo == '0) ? '0 : bus.tempo - TEMPO_W'(1);
    assign w_cnt_inc    = (&r_cnt) ? r_cnt : r_cnt + TEMPO_W'(1);
    // Indices past a lowered last_idx also wrap to entry 0
    assign w_adv_idx    = (r_step_idx >= bus.last_idx) ? '0 : r_step_idx + IDX_W'(1);
    assign w_all_done   = w_period_done && w_duty_done;

    // Next-state logic: issue entry, wait out the tempo, then advance or stop
    // NOTE: every signal gets a default first so no path leaves it unassigned (no latches).
    always_comb begin
        w_state_nxt    = r_state;
        w_cnt_nxt      = r_cnt;
        w_step_idx_nxt = r_step_idx;
        w_load         = 1'b0;
        w_load_idx     = r_step_idx;
        w_overrun_set  = 1'b0;
        w_step_end     = 1'b0;

        case (r_state)
            IDLE: begin
                if (bus.run) begin
                    w_state_nxt = ISSUE;
                    w_cnt_nxt   = '0;
                    w_load      = 1'b1;
                end
            end
            ISSUE: begin
                w_cnt_nxt = w_cnt_inc;
                if (!w_all_done && (r_cnt >= w_limit)) begin
                    w_overrun_set = 1'b1;
                end
                // A beat finishing in the very first issue cycle still needs its
                // vld-low cycle, so that case always passes through WAIT.
                if (w_all_done) begin
                    if ((r_cnt >= w_limit) && (r_cnt != '0)) begin
                        w_step_end = 1'b1;
                    end else begin
                        w_state_nxt = WAIT;
                    end
                end
            end
            WAIT: begin
                w_cnt_nxt = w_cnt_inc;
                if (r_cnt >= w_limit) begin
                    w_step_end = 1'b1;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase

        // Common step-end handling for both the ISSUE and WAIT exits
        if (w_step_end) begin
            if (bus.run) begin
                w_state_nxt    = ISSUE;
                w_cnt_nxt      = '0;
                w_step_idx_nxt = w_adv_idx;
                w_load         = 1'b1;
                w_load_idx     = w_adv_idx;
            end else begin
                w_state_nxt    = IDLE;
                w_step_idx_nxt = '0;
            end
        end
    end

    // State, tempo counter, step index and sticky overrun flag
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= IDLE;
            r_cnt      <= '0;
            r_step_idx <= '0;
            r_overrun  <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_cnt      <= w_cnt_nxt;
            r_step_idx <= w_step_idx_nxt;
            if (w_overrun_set) begin
                r_overrun <= 1'b1;
            end
        end
    end

    apu_stream_out #(.W($bits(period_t))) u_period_out (
        .clk    (clk),
        .rst_n  (rst_n),
        .i_load (w_load),
        .i_data (w_load_entry.period),
        .i_rdy  (bus.period_rdy),
        .o_data (bus.period),
        .o_vld  (bus.period_vld),
        .o_done (w_period_done)
    );

    apu_stream_out #(.W($bits(duty_t))) u_duty_out (
        .clk    (clk),
        .rst_n  (rst_n),
        .i_load (w_load),
        .i_data (w_load_entry.duty),
        .i_rdy  (bus.duty_rdy),
        .o_data (bus.duty),
        .o_vld  (bus.duty_vld),
        .o_done (w_duty_done)
    );

    assign bus.step_idx = r_step_idx;
    assign bus.busy     = (r_state != IDLE);
    assign bus.overrun  = r_overrun;

endmodule

// File: tb/tb_apu_pulse_sequencer.sv
// Self-checking bench: directed scenarios plus random traffic against a step-timeline model.
module tb_apu_pulse_sequencer;
    import apu_pkg::*;

    localparam int DEPTH   = 8;
    localparam int TEMPO_W = 16;
    localparam int IDX_W   = 3;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    apu_pulse_sequencer_if #(.DEPTH(DEPTH), .TEMPO_W(TEMPO_W)) bus ();

    apu_pulse_sequencer #(.DEPTH(DEPTH), .TEMPO_W(TEMPO_W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.master)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Reference model: a step is a timeline of elapsed clocks with two pending beats
    int m_tab_p [DEPTH];
    int m_tab_d [DEPTH];
    bit m_active, m_ppend, m_dpend, m_ovr;
    int m_el, m_idx, m_per, m_dut;

    int cyc;
    int pq[$], pv[$], dq[$], dv[$];
    int exp_p[5] = '{100, 200, 300, 400, 100};
    int exp_d[5] = '{0, 1, 2, 3, 0};

    task automatic model_reset();
        m_active = 0; m_ppend = 0; m_dpend = 0; m_ovr = 0;
        m_el = 0; m_idx = 0; m_per = 0; m_dut = 0;
    endtask

    task automatic model_issue();
        m_el = 0; m_ppend = 1; m_dpend = 1;
        m_per = m_tab_p[m_idx];
        m_dut = m_tab_d[m_idx];
    endtask

    // Advance the model across one clock edge using the inputs currently driven
    task automatic model_step();
        int lim;
        bit pa, da, step_end;
        lim = (bus.tempo == 0) ? 0 : int'(bus.tempo) - 1;
        if (!m_active) begin
            if (bus.run) begin
                m_active = 1;
                model_issue();
            end
        end else begin
            pa = m_ppend && !bus.period_rdy;
            da = m_dpend && !bus.duty_rdy;
            if (m_ppend || m_dpend) begin
                if ((pa || da) && m_el >= lim) m_ovr = 1;
                step_end = !(pa || da) && (m_el >= lim) && (m_el > 0);
            end else begin
                step_end = (m_el >= lim);
            end
            m_el++;
            m_ppend = pa;
            m_dpend = da;
            if (step_end) begin
                if (bus.run) begin
                    m_idx = (m_idx >= int'(bus.last_idx)) ? 0 : m_idx + 1;
                    model_issue();
                end else begin
                    m_idx = 0;
                    m_active = 0;
                end
            end
        end
        // Table write lands after the issue read of the same edge
        if (bus.cfg_we) begin
            m_tab_p[bus.cfg_addr] = int'(bus.cfg_period);
            m_tab_d[bus.cfg_addr] = int'(bus.cfg_duty);
        end
    endtask

    task automatic compare_all();
        check("period",     32'(bus.period),     32'(m_per));
        check("duty",       32'(bus.duty),       32'(m_dut));
        check("period_vld", 32'(bus.period_vld), 32'(m_ppend));
        check("duty_vld",   32'(bus.duty_vld),   32'(m_dpend));
        check("step_idx",   32'(bus.step_idx),   32'(m_idx));
        check("busy",       32'(bus.busy),       32'(m_active));
        check("overrun",    32'(bus.overrun),    32'(m_ovr));
    endtask

    // One clock: log transfers seen this cycle, step the model, sample #1 after the edge
    task automatic tick();
        if (bus.period_vld && bus.period_rdy) begin
            pq.push_back(cyc);
            pv.push_back(int'(bus.period));
        end
        if (bus.duty_vld && bus.duty_rdy) begin
            dq.push_back(cyc);
            dv.push_back(int'(bus.duty));
        end
        model_step();
        @(posedge clk);
        #1;
        cyc++;
        compare_all();
    endtask

    task automatic clear_log();
        pq.delete(); pv.delete(); dq.delete(); dv.delete();
        cyc = 0;
    endtask

    task automatic reset_dut();
        bus.run    = 1'b0;
        bus.cfg_we = 1'b0;
        rst_n      = 1'b0;
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        clear_log();
    endtask

    task automatic write_entry(input int a, input int p, input int d);
        bus.cfg_we     = 1'b1;
        bus.cfg_addr   = IDX_W'(a);
        bus.cfg_period = period_t'(p);
        bus.cfg_duty   = duty_t'(d);
        tick();
        bus.cfg_we     = 1'b0;
    endtask

    task automatic load_demo();
        for (int i = 0; i < 4; i++) write_entry(i, exp_p[i], exp_d[i]);
    endtask

    initial begin
        bus.cfg_we = 0; bus.cfg_addr = '0; bus.cfg_period = '0; bus.cfg_duty = '0;
        bus.last_idx = 3'd3; bus.tempo = 16'd10; bus.run = 0;
        bus.period_rdy = 1; bus.duty_rdy = 1;
        model_reset();
        #3;
        compare_all();

        // Basic loop: four entries, tempo 10, always ready
        reset_dut();
        load_demo();
        clear_log();
        bus.run = 1;
        repeat (45) tick();
        check("t1_pbeats", pq.size(), 5);
        check("t1_dbeats", dq.size(), 5);
        for (int i = 0; i < 5 && i < pq.size() && i < dq.size(); i++) begin
            check("t1_pval", pv[i], exp_p[i]);
            check("t1_dval", dv[i], exp_d[i]);
            if (i > 0) check("t1_gap", pq[i] - pq[i-1], 10);
        end
        check("t1_ovr", bus.overrun, 0);

        // Duty stalled for 15 cycles of step 0
        reset_dut();
        bus.tempo = 10;
        bus.duty_rdy = 0;
        bus.run = 1;
        tick();
        repeat (15) tick();
        bus.duty_rdy = 1;
        repeat (5) tick();
        check("t2_ovr", bus.overrun, 1);
        if (pq.size() >= 2 && dq.size() >= 1) begin
            check("t2_pbeat0", pq[0], 1);
            check("t2_dbeat0", dq[0], 16);
            check("t2_pbeat1", pq[1], 17);
            check("t2_pval1",  pv[1], 200);
        end else begin
            check("t2_beats", pq.size() * 10 + dq.size(), 21);
        end

        // run dropped while the period beat is stalled
        reset_dut();
        bus.tempo = 10;
        bus.period_rdy = 0;
        bus.run = 1;
        tick();
        bus.run = 0;
        repeat (5) tick();
        check("t3_hold_vld", bus.period_vld, 1);
        check("t3_hold_dat", bus.period, 100);
        bus.period_rdy = 1;
        repeat (12) tick();
        check("t3_busy", bus.busy, 0);
        check("t3_idx",  bus.step_idx, 0);
        check("t3_vld",  bus.period_vld, 0);

        // tempo 0 and 1: one beat every two clocks
        for (int t = 0; t < 2; t++) begin
            reset_dut();
            bus.tempo = 16'(t);
            bus.run = 1;
            repeat (12) tick();
            check("t4_beats", pq.size() >= 5, 1);
            for (int i = 0; i < 5 && i < pq.size(); i++) begin
                check("t4_pval", pv[i], exp_p[i]);
                if (i > 0) check("t4_gap", pq[i] - pq[i-1], 2);
            end
        end

        // Rewrite the entry that is in flight
        reset_dut();
        bus.tempo = 10;
        bus.period_rdy = 0;
        bus.run = 1;
        tick();
        write_entry(0, 777, 2);
        check("t5_pstable", bus.period, 100);
        check("t5_dstable", bus.duty, 0);
        bus.period_rdy = 1;
        repeat (45) tick();
        check("t5_beats", pq.size() >= 5, 1);
        if (pq.size() >= 5) begin
            check("t5_first", pv[0], 100);
            check("t5_pnew",  pv[4], 777);
            check("t5_dnew",  dv[4], 2);
        end

        // Asynchronous reset in the middle of a stalled issue
        reset_dut();
        bus.tempo = 2;
        bus.run = 1;
        repeat (5) tick();
        bus.period_rdy = 0;
        bus.duty_rdy = 0;
        repeat (4) tick();
        check("t6_pre_ovr", bus.overrun, 1);
        #2;
        rst_n = 1'b0;
        #1;
        check("t6_pvld", bus.period_vld, 0);
        check("t6_dvld", bus.duty_vld, 0);
        check("t6_idx",  bus.step_idx, 0);
        check("t6_ovr",  bus.overrun, 0);
        check("t6_busy", bus.busy, 0);
        bus.period_rdy = 1;
        bus.duty_rdy = 1;

        // Random traffic against the model
        reset_dut();
        for (int i = 0; i < DEPTH; i++) write_entry(i, int'($urandom_range(0, 2047)), int'($urandom_range(0, 3)));
        bus.last_idx = IDX_W'($urandom_range(0, DEPTH - 1));
        bus.tempo = 16'($urandom_range(0, 5));
        bus.run = 1;
        for (int n = 0; n < 1500; n++) begin
            bus.period_rdy = ($urandom_range(0, 3) != 0);
            bus.duty_rdy   = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 39) == 0) bus.run = ~bus.run;
            if ($urandom_range(0, 59) == 0) bus.tempo = 16'($urandom_range(0, 6));
            if ($urandom_range(0, 79) == 0) bus.last_idx = IDX_W'($urandom_range(0, DEPTH - 1));
            bus.cfg_we     = ($urandom_range(0, 7) == 0);
            bus.cfg_addr   = IDX_W'($urandom_range(0, DEPTH - 1));
            bus.cfg_period = period_t'($urandom_range(0, 2047));
            bus.cfg_duty   = duty_t'($urandom_range(0, 3));
            tick();
        end
        bus.cfg_we = 0;

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
